spi_master_controller: RTL and testbench

Sequencing controller for the SPI byte path. It accepts a byte-transfer request from the host and generates SCLK and SS_N. It drives the `sender` (WRITE/TE) and `receiver` (READ/RE) control pins so that one full-duplex 8-bit exchange happens per request, then returns the received byte with a one-cycle DONE pulse. It sits between the host logic and the sender/receiver pair, and its SCLK output clocks both.

---
 rtl/spi_master_controller_pkg.sv | 15 +
 rtl/spi_master_controller_if.sv | 45 ++++
 rtl/spi_master_controller_clk_gen.sv | 52 +++++
 rtl/spi_master_controller.sv | 144 ++++++++++++++
 tb/tb_spi_master_controller.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_controller_pkg.sv
// Shared types and constants for the SPI byte-path sequencing controller.
package spi_ctrl_pkg;

  localparam int SPI_BYTE_BITS = 8;
  localparam int BIT_CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    READ   = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/spi_master_controller_if.sv
// Host, sender and receiver signal bundle for spi_master_controller.
// The o_err member exists only when SPI_CTRL_CHECK_EN is defined.
interface spi_master_controller_if;
  import spi_ctrl_pkg::*;

  logic                     i_start;
  logic [SPI_BYTE_BITS-1:0] i_tx_data;
  logic [SPI_BYTE_BITS-1:0] o_rx_data;
  logic                     o_busy;
  logic                     o_done;
`ifdef SPI_CTRL_CHECK_EN
  logic                     o_err;
`endif
  logic                     o_sclk;
  logic                     o_ss_n;
  logic [SPI_BYTE_BITS-1:0] o_snd_data;
  logic                     o_snd_write;
  logic                     o_snd_te;
  logic                     i_snd_empty;
  logic                     o_rcv_read;
  logic                     o_rcv_re;
  logic                     i_rcv_full;
  logic [SPI_BYTE_BITS-1:0] i_rcv_data;

  // Controller side.
  modport master (
`ifdef SPI_CTRL_CHECK_EN
    output o_err,
`endif
    input  i_start, i_tx_data, i_snd_empty, i_rcv_full, i_rcv_data,
    output o_rx_data, o_busy, o_done, o_sclk, o_ss_n,
    output o_snd_data, o_snd_write, o_snd_te, o_rcv_read, o_rcv_re
  );

  // Host / sender / receiver side.
  modport slave (
`ifdef SPI_CTRL_CHECK_EN
    input  o_err,
`endif
    output i_start, i_tx_data, i_snd_empty, i_rcv_full, i_rcv_data,
    input  o_rx_data, o_busy, o_done, o_sclk, o_ss_n,
    input  o_snd_data, o_snd_write, o_snd_te, o_rcv_read, o_rcv_re
  );

endinterface

// File: rtl/spi_master_controller_clk_gen.sv
// SCLK divider: low for CLK_DIV cycles, high for CLK_DIV cycles, with a
// one-cycle tick on the last cycle of each period. Held low while disabled.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sclk,
  output logic o_tick
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  // Half-period count plus the SCLK phase keeps the counter 8 bits wide
  // over the whole 1..255 range of CLK_DIV.
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       r_sclk;
  logic       w_sclk_next;
  logic       w_half_end;

  assign w_half_end = (r_cnt == HALF_LAST);

  always_comb begin
    w_cnt_next  = r_cnt;
    w_sclk_next = r_sclk;
    if (!i_en) begin
      w_cnt_next  = 8'd0;
      w_sclk_next = 1'b0;
    end else if (w_half_end) begin
      w_cnt_next  = 8'd0;
      w_sclk_next = ~r_sclk;
    end else begin
      w_cnt_next  = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_cnt  <= 8'd0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_sclk <= w_sclk_next;
    end
  end

  assign o_sclk = r_sclk;
  assign o_tick = i_en & r_sclk & w_half_end;

endmodule

// File: rtl/spi_master_controller.sv
// SPI byte-path sequencer: one full-duplex 8-bit exchange per START request.
// Define SPI_CTRL_CHECK_EN to add the sticky ERR sender/receiver handshake check.
module spi_master_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  spi_master_controller_if.master bus
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(SPI_BYTE_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_master_controller: CLK_DIV must be within 1..255");
  end

  state_t                   r_state;
  state_t                   w_state_next;
  logic [BIT_CNT_W-1:0]     r_bit_cnt;
  logic [BIT_CNT_W-1:0]     w_bit_cnt_next;
  logic [SPI_BYTE_BITS-1:0] r_rx_data;
  logic [SPI_BYTE_BITS-1:0] w_rx_data_next;
  logic [SPI_BYTE_BITS-1:0] r_snd_data;
  logic [SPI_BYTE_BITS-1:0] w_snd_data_next;

  logic w_clk_en;
  logic w_sclk;
  logic w_tick;
  logic w_ss_n;
  logic w_snd_write;
  logic w_snd_te;
  logic w_rcv_read;
  logic w_rcv_re;
  logic w_done;

  assign w_clk_en = (r_state == LOAD) || (r_state == SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk  (i_clk),
    .i_clr  (i_clr),
    .i_en   (w_clk_en),
    .o_sclk (w_sclk),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_rx_data_next  = r_rx_data;
    w_snd_data_next = r_snd_data;
    w_ss_n          = 1'b1;
    w_snd_write     = 1'b0;
    w_snd_te        = 1'b0;
    w_rcv_read      = 1'b0;
    w_rcv_re        = 1'b0;
    w_done          = 1'b0;

    case (r_state)
      IDLE: begin
        w_bit_cnt_next = '0;
        if (bus.i_start) begin
          w_snd_data_next = bus.i_tx_data;
          w_state_next    = LOAD;
        end
      end
      LOAD: begin
        w_ss_n      = 1'b0;
        w_snd_write = 1'b1;
        w_snd_te    = 1'b1;
        if (w_tick) w_state_next = SHIFT;
      end
      SHIFT: begin
        w_ss_n   = 1'b0;
        w_snd_te = 1'b1;
        w_rcv_re = 1'b1;
        if (w_tick) begin
          w_bit_cnt_next = r_bit_cnt + BIT_ONE;
          if (r_bit_cnt == BIT_LAST) w_state_next = READ;
        end
      end
      READ: begin
        w_ss_n         = 1'b0;
        w_rcv_read     = 1'b1;
        w_rx_data_next = bus.i_rcv_data;
        w_state_next   = FINISH;
      end
      FINISH: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_rx_data  <= '0;
      r_snd_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_rx_data  <= w_rx_data_next;
      r_snd_data <= w_snd_data_next;
    end
  end

`ifdef SPI_CTRL_CHECK_EN
  // Both halves of the byte path must have completed by the READ cycle.
  logic r_err;
  logic w_err_next;

  assign w_err_next = r_err |
                      ((r_state == READ) & ~(bus.i_snd_empty & bus.i_rcv_full));

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) r_err <= 1'b0;
    else       r_err <= w_err_next;
  end

  assign bus.o_err = r_err;
`else
  logic w_unused_chk;
  assign w_unused_chk = &{1'b0, bus.i_snd_empty, bus.i_rcv_full};
`endif

  assign bus.o_rx_data   = r_rx_data;
  assign bus.o_snd_data  = r_snd_data;
  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_done      = w_done;
  assign bus.o_sclk      = w_sclk;
  assign bus.o_ss_n      = w_ss_n;
  assign bus.o_snd_write = w_snd_write;
  assign bus.o_snd_te    = w_snd_te;
  assign bus.o_rcv_read  = w_rcv_read;
  assign bus.o_rcv_re    = w_rcv_re;

endmodule

// File: tb/tb_spi_master_controller.sv
// Scoreboard bench for spi_master_controller (CLK_DIV=4); covers the
// SPI_CTRL_CHECK_EN ERR path when that macro is defined.
module tb_spi_master_controller;

  localparam int DIV       = 4;
  localparam int DONE_CYC  = 18 * DIV + 2;   // 74
  localparam int WRITE_CYC = 2 * DIV;        // 8
  localparam int SS_LOW    = 18 * DIV + 1;   // 73
  localparam int SCLK_RISE = 9;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] snd;
    int         cyc;
  } exp_t;

  logic clk;
  logic clr;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   n_done;
  int   n_exp_done;
  exp_t sb[$];

  spi_master_controller_if bus();

  spi_master_controller #(
    .CLK_DIV (DIV)
  ) dut (
    .i_clk (clk),
    .i_clr (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: per-transfer activity counters, scoreboard pop on every DONE.
  int   mon_write;
  int   mon_ss_low;
  int   mon_rise;
  logic mon_prev_sclk;
  exp_t mon_e;

  always @(negedge clk) begin
    if (clr) begin
      mon_write     = 0;
      mon_ss_low    = 0;
      mon_rise      = 0;
      mon_prev_sclk = 1'b0;
    end else begin
      if (bus.o_snd_write) mon_write++;
      if (!bus.o_ss_n) mon_ss_low++;
      if (bus.o_sclk && !mon_prev_sclk) mon_rise++;
      mon_prev_sclk = bus.o_sclk;
      if (bus.o_done) begin
        n_done++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got DONE at cyc %0d, required none", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("rx_data",    32'(bus.o_rx_data),  32'(mon_e.rx));
          check("snd_data",   32'(bus.o_snd_data), 32'(mon_e.snd));
          check("done_cycle", 32'(cyc),            32'(mon_e.cyc));
          check("write_cyc",  32'(mon_write),      32'(WRITE_CYC));
          check("sclk_rises", 32'(mon_rise),       32'(SCLK_RISE));
          check("ss_low_cyc", 32'(mon_ss_low),     32'(SS_LOW));
          check("ss_n_done",  32'(bus.o_ss_n),     32'd1);
          check("sclk_done",  32'(bus.o_sclk),     32'd0);
          $display("xfer cyc=%0d snd=%02h rx=%02h write=%0d rises=%0d ss_low=%0d",
                   cyc, bus.o_snd_data, bus.o_rx_data, mon_write, mon_rise, mon_ss_low);
        end
        mon_write  = 0;
        mon_ss_low = 0;
        mon_rise   = 0;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.o_busy),      32'd0);
    check({tag, "_done"},  32'(bus.o_done),      32'd0);
    check({tag, "_ss_n"},  32'(bus.o_ss_n),      32'd1);
    check({tag, "_sclk"},  32'(bus.o_sclk),      32'd0);
    check({tag, "_write"}, 32'(bus.o_snd_write), 32'd0);
    check({tag, "_te"},    32'(bus.o_snd_te),    32'd0);
    check({tag, "_read"},  32'(bus.o_rcv_read),  32'd0);
    check({tag, "_re"},    32'(bus.o_rcv_re),    32'd0);
  endtask

  // START is sampled at the edge ending cycle 0; cyc during cycle k is e+k.
  task automatic issue(input logic [7:0] tx, input logic [7:0] rx, output int e);
    @(negedge clk);
    check("busy_pre_start", 32'(bus.o_busy), 32'd0);
    bus.i_start    = 1'b1;
    bus.i_tx_data  = tx;
    bus.i_rcv_data = rx;
    e = cyc;
    sb.push_back('{rx, tx, e + DONE_CYC});
    n_exp_done++;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("busy_cycle1", 32'(bus.o_busy), 32'd1);
    check("ss_n_cycle1", 32'(bus.o_ss_n), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_done && n < 400);
    if (!bus.o_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: no DONE after %0d cycles, required DONE", tag, n);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  logic [7:0] held_tx [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] held_rx [3] = '{8'hEE, 8'hDD, 8'hCC};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    cyc            = 0;
    n_cmp          = 0;
    n_bad          = 0;
    n_done         = 0;
    n_exp_done     = 0;
    clr            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_tx_data  = 8'h00;
    bus.i_rcv_data = 8'h00;
    bus.i_snd_empty = 1'b1;
    bus.i_rcv_full  = 1'b1;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_rx_data",  32'(bus.o_rx_data),  32'h00);
    check("rst_snd_data", 32'(bus.o_snd_data), 32'h00);
`ifdef SPI_CTRL_CHECK_EN
    check("rst_err", 32'(bus.o_err), 32'd0);
`endif
    clr = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // Single transfer A5 out, 3C back.
    issue(8'hA5, 8'h3C, e);
    wait_done("single");

    // START pulse mid-transfer must be ignored.
    issue(8'h5A, 8'hC3, e);
    wait_cyc(e + 20);
    bus.i_start   = 1'b1;
    bus.i_tx_data = 8'hFF;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done("busy_start");
    repeat (20) @(negedge clk);
    check("idle_after_ignored_start", 32'(bus.o_busy), 32'd0);

    // START held high: back-to-back transfers every 75 cycles.
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_tx_data  = held_tx[0];
    bus.i_rcv_data = held_rx[0];
    sb.push_back('{held_rx[0], held_tx[0], cyc + DONE_CYC});
    n_exp_done++;
    for (int i = 0; i < 3; i++) begin
      wait_done("held");
      if (i < 2) begin
        bus.i_tx_data  = held_tx[i+1];
        bus.i_rcv_data = held_rx[i+1];
        sb.push_back('{held_rx[i+1], held_tx[i+1], cyc + 1 + DONE_CYC});
        n_exp_done++;
      end else begin
        bus.i_start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // CLR at cycle 40 aborts the transfer with no DONE.
    issue(8'hF0, 8'h81, e);
    wait_cyc(e + 40);
    check("sclk_high_before_clr", 32'(bus.o_sclk), 32'd1);
    #1 clr = 1'b1;
    #1;
    check_idle_outputs("clr_mid");
    sb.delete();
    n_exp_done--;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    issue(8'h0F, 8'h96, e);
    wait_done("after_clr");
    repeat (3) @(negedge clk);

`ifdef SPI_CTRL_CHECK_EN
    check("err_before_fault", 32'(bus.o_err), 32'd0);
    bus.i_rcv_full = 1'b0;
    issue(8'h3C, 8'hA5, e);
    wait_done("err_fault");
    check("err_set", 32'(bus.o_err), 32'd1);
    bus.i_rcv_full = 1'b1;
    issue(8'h77, 8'h88, e);
    wait_done("err_good");
    check("err_sticky", 32'(bus.o_err), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("err_cleared", 32'(bus.o_err), 32'd0);
    clr = 1'b0;
    repeat (2) @(negedge clk);
`endif

    check("done_count", 32'(n_done), 32'(n_exp_done));
    check("sb_empty",   32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
